// File: rtl/popcount_arbiter.sv
// popcount_arbiter
//
// Accepts a batch of InCnt request words plus a participation mask and
// grants the participating requester whose word has the most set bits.
// One entry is evaluated per cycle through a single shared count_ones
// instance. Ties go to the lowest index.
//
// Ports:
//   clk_i        clock, all state updates on the rising edge
//   rst_i        synchronous active-high reset
//   in_valid_i   batch valid
//   in_ready_o   block can accept a batch (IDLE and not in reset)
//   data_i       request words, entry k at [k*InWdt +: InWdt]
//   mask_i       bit k=1: entry k participates
//   out_valid_o  result valid
//   out_ready_i  consumer accepts the result
//   out_idx_o    winning entry index
//   out_cnt_o    popcount of the winning entry
//   out_none_o   no entry participated

module count_ones #(
    parameter int InWdt  = 8,
    parameter int CntWdt = 16
) (
    input  logic [InWdt-1:0]  word,
    output logic [CntWdt-1:0] cnt
);
    always_comb begin
        cnt = '0;
        for (int i = 0; i < InWdt; i++) begin
            cnt = cnt + CntWdt'(word[i]);
        end
    end
endmodule

// state | meaning
// IDLE  | waiting for a batch, in_ready_o=1
// SCAN  | evaluating entry ptr, one per cycle
// DONE  | result presented, waiting for out_ready_i
module popcount_arbiter #(
    parameter int InCnt  = 4,
    parameter int InWdt  = 8,
    parameter int CntWdt = 16,
    localparam int IdxWdt = $clog2(InCnt)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [InCnt*InWdt-1:0] data_i,
    input  logic [InCnt-1:0]       mask_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [IdxWdt-1:0]      out_idx_o,
    output logic [CntWdt-1:0]      out_cnt_o,
    output logic                   out_none_o
);
    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t state_q, state_d;

    logic [InCnt-1:0][InWdt-1:0] data_q;
    logic [InCnt-1:0]            mask_q;
    logic [IdxWdt-1:0]           ptr_q;
    logic [CntWdt-1:0]           best_cnt_q;
    logic [IdxWdt-1:0]           best_idx_q;
    logic                        found_q;

    logic [InWdt-1:0]  cur_word;
    logic [CntWdt-1:0] cur_cnt;
    logic              last;
    logic              take;

    assign cur_word = data_q[ptr_q];

    count_ones #(
        .InWdt  (InWdt),
        .CntWdt (CntWdt)
    ) u_count_ones (
        .word (cur_word),
        .cnt  (cur_cnt)
    );

    assign last = (ptr_q == IdxWdt'(InCnt - 1));
    // Strict greater-than keeps the earlier (lower-index) entry on a tie.
    assign take = mask_q[ptr_q] && (!found_q || (cur_cnt > best_cnt_q));

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (in_valid_i)  state_d = SCAN;
            SCAN: if (last)        state_d = DONE;
            DONE: if (out_ready_i) state_d = IDLE;
            default:               state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            data_q     <= '0;
            mask_q     <= '0;
            ptr_q      <= '0;
            best_cnt_q <= '0;
            best_idx_q <= '0;
            found_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (in_valid_i) begin
                        data_q     <= data_i;
                        mask_q     <= mask_i;
                        ptr_q      <= '0;
                        best_cnt_q <= '0;
                        best_idx_q <= '0;
                        found_q    <= 1'b0;
                    end
                end
                SCAN: begin
                    if (take) begin
                        best_cnt_q <= cur_cnt;
                        best_idx_q <= ptr_q;
                        found_q    <= 1'b1;
                    end
                    if (!last) begin
                        ptr_q <= ptr_q + IdxWdt'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs decode from state and registered best values only, so they hold
    // stable under backpressure and have no path from the handshake inputs.
    assign in_ready_o  = (state_q == IDLE) && !rst_i;
    assign out_valid_o = (state_q == DONE);
    assign out_none_o  = (state_q == DONE) && !found_q;
    assign out_idx_o   = found_q ? best_idx_q : '0;
    assign out_cnt_o   = found_q ? best_cnt_q : '0;
endmodule

// File: tb/tb_popcount_arbiter.sv
// Testbench for popcount_arbiter: scoreboard of expected results pushed at
// batch acceptance and compared when the DUT hands a result over.

module tb_popcount_arbiter;
    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] data_i;
    logic [3:0]  mask_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [1:0]  out_idx_o;
    logic [15:0] out_cnt_o;
    logic        out_none_o;

    typedef struct {
        logic [1:0]  idx;
        logic [15:0] cnt;
        logic        none;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   n_res = 0;

    popcount_arbiter #(
        .InCnt  (4),
        .InWdt  (8),
        .CntWdt (16)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .data_i      (data_i),
        .mask_i      (mask_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_idx_o   (out_idx_o),
        .out_cnt_o   (out_cnt_o),
        .out_none_o  (out_none_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk_i) begin
        if (!rst_i && out_valid_o && out_ready_i) begin
            n_res++;
            if (sb.size() == 0) begin
                check_val("unexp_out", 32'(sb.size()), 32'd1);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check_val("out_idx",  32'(out_idx_o),  32'(e.idx));
                check_val("out_cnt",  32'(out_cnt_o),  32'(e.cnt));
                check_val("out_none", 32'(out_none_o), 32'(e.none));
            end
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [31:0] d, input logic [3:0] m, input logic [1:0] ei,
                        input logic [15:0] ec, input logic en, input bit push);
        int   t;
        exp_t e;
        t = 0;
        data_i     = d;
        mask_i     = m;
        in_valid_i = 1'b1;
        @(negedge clk_i);
        while (!in_ready_o && t < 40) begin
            @(negedge clk_i);
            t++;
        end
        if (!in_ready_o) begin
            check_val("accept_timeout", 32'(in_ready_o), 32'd1);
            in_valid_i = 1'b0;
            return;
        end
        if (push) begin
            e.idx  = ei;
            e.cnt  = ec;
            e.none = en;
            sb.push_back(e);
        end
        @(posedge clk_i);
        #1 in_valid_i = 1'b0;
    endtask

    task automatic wait_results(input int n);
        int t;
        t = 0;
        while (n_res < n && t < 40) begin
            @(posedge clk_i);
            #1;
            t++;
        end
        if (n_res < n) check_val("result_timeout", 32'(n_res), 32'(n));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  h_idx;
        logic [15:0] h_cnt;
        logic        h_none;
        bit          stable_ok;
        bit          busy_seen;
        bit          valid_seen;
        int          t;
        int          saved;

        rst_i       = 1'b1;
        in_valid_i  = 1'b0;
        data_i      = '0;
        mask_i      = '0;
        out_ready_i = 1'b1;

        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        check_val("rst_valid", 32'(out_valid_o), 32'd0);
        check_val("rst_idx",   32'(out_idx_o),   32'd0);
        check_val("rst_cnt",   32'(out_cnt_o),   32'd0);
        check_val("rst_none",  32'(out_none_o),  32'd0);
        check_val("rst_ready", 32'(in_ready_o),  32'd0);
        @(posedge clk_i);
        #1 rst_i = 1'b0;
        @(negedge clk_i);
        check_val("ready_after_rst", 32'(in_ready_o), 32'd1);

        // Basic, with latency: valid low for edges E0..E3, high after E4.
        @(posedge clk_i);
        #1;
        send(32'h00FF0FAA, 4'b1111, 2'd2, 16'd8, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            check_val("latency_low", 32'(out_valid_o), 32'd0);
        end
        @(negedge clk_i);
        check_val("latency_high", 32'(out_valid_o), 32'd1);
        wait_results(1);
        send(32'h40FEFF55, 4'b1111, 2'd1, 16'd8, 1'b0, 1'b1);
        wait_results(2);

        // Ties and masks.
        send(32'h0033F00F, 4'b1111, 2'd0, 16'd4, 1'b0, 1'b1);
        wait_results(3);
        send(32'h00FF0FAA, 4'b1011, 2'd0, 16'd4, 1'b0, 1'b1);
        wait_results(4);
        send(32'h00FF0FAA, 4'b1000, 2'd3, 16'd0, 1'b0, 1'b1);
        wait_results(5);

        // Empty mask.
        send(32'h12345678, 4'b0000, 2'd0, 16'd0, 1'b1, 1'b1);
        wait_results(6);

        // Backpressure: outputs hold, in_ready low, extra batch ignored.
        out_ready_i = 1'b0;
        send(32'h40FEFF55, 4'b1111, 2'd1, 16'd8, 1'b0, 1'b1);
        t = 0;
        @(negedge clk_i);
        while (!out_valid_o && t < 20) begin
            @(negedge clk_i);
            t++;
        end
        check_val("bp_valid", 32'(out_valid_o), 32'd1);
        h_idx  = out_idx_o;
        h_cnt  = out_cnt_o;
        h_none = out_none_o;
        data_i     = 32'hFFFFFFFF;
        mask_i     = 4'b1111;
        in_valid_i = 1'b1;
        stable_ok  = 1'b1;
        busy_seen  = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_i);
            if (!out_valid_o || out_idx_o !== h_idx || out_cnt_o !== h_cnt || out_none_o !== h_none)
                stable_ok = 1'b0;
            if (in_ready_o) busy_seen = 1'b1;
        end
        check_val("bp_stable", 32'(stable_ok), 32'd1);
        check_val("bp_ready_low", 32'(busy_seen), 32'd0);
        @(posedge clk_i);
        #1;
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        @(negedge clk_i);
        check_val("bp_ready_hold", 32'(in_ready_o), 32'd0);
        @(negedge clk_i);
        check_val("bp_ready_after", 32'(in_ready_o), 32'd1);
        check_val("bp_valid_after", 32'(out_valid_o), 32'd0);
        saved = n_res;
        repeat (12) @(negedge clk_i);
        check_val("bp_no_second", 32'(n_res), 32'(saved));

        // Input change after accept.
        @(posedge clk_i);
        #1;
        send(32'h00FF0FAA, 4'b1111, 2'd2, 16'd8, 1'b0, 1'b1);
        @(posedge clk_i);
        #1;
        data_i = 32'hFFFFFFFF;
        mask_i = 4'b0000;
        wait_results(saved + 1);

        // Reset during the second SCAN cycle discards the batch.
        send(32'hFFFFFFFF, 4'b1111, 2'd0, 16'd8, 1'b0, 1'b0);
        @(posedge clk_i);
        #1 rst_i = 1'b1;
        @(negedge clk_i);
        check_val("midrst_ready_low", 32'(in_ready_o), 32'd0);
        @(posedge clk_i);
        #1 rst_i = 1'b0;
        @(negedge clk_i);
        check_val("midrst_ready_high", 32'(in_ready_o), 32'd1);
        saved = n_res;
        valid_seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_i);
            if (out_valid_o) valid_seen = 1'b1;
        end
        check_val("midrst_no_out", 32'(valid_seen), 32'd0);
        @(posedge clk_i);
        #1;
        send(32'h0F070301, 4'b1111, 2'd3, 16'd4, 1'b0, 1'b1);
        wait_results(saved + 1);
        check_val("sb_empty", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
